// File: rtl/conv2d_mc_pkg.sv
// conv2d_mc_pkg: shared types and helpers for the multi-channel conv2d engine.
//   state_t      - controller FSM states
//   out_dim      - output spatial size for a given input/kernel/stride/padding
//   nchw_addr    - flat address of an NCHW tensor element
//   oihw_addr    - flat address of an OIHW weight element
//   sat_shift    - arithmetic shift, optional ReLU clamp, signed saturation
package conv2d_mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_WRITE, S_FIN
  } state_t;

  // Counter width used by the address generator for every loop index.
  localparam int CNT_W = 16;

  function automatic int out_dim(int in_sz, int k, int s, int p);
    return (in_sz + 2 * p - k) / s + 1;
  endfunction

  function automatic int nchw_addr(int n, int c, int y, int x, int nc, int h, int w);
    return ((n * nc + c) * h + y) * w + x;
  endfunction

  function automatic int oihw_addr(int o, int i, int ky, int kx, int ni, int k);
    return ((o * ni + i) * k + ky) * k + kx;
  endfunction

  // Shift first, clamp negatives when relu is set, then saturate to dw bits.
  function automatic longint sat_shift(longint acc, int shift, bit relu, int dw);
    longint r;
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (dw - 1)) - 1;
    lo = -(longint'(1) <<< (dw - 1));
    r  = acc >>> shift;
    if (relu && r < 0) r = 0;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/conv2d_mc_addr_gen.sv
// conv2d_mc_addr_gen: nested loop counters and address generation.
//   Loop order (outer to inner): b, oc, oy, ox for pixels; ic, ky, kx for taps.
//   clr       - zero every counter
//   tap_step  - advance the tap counters (wrap to 0 after the last tap)
//   pix_step  - advance the pixel counters (wrap to 0 after the last pixel)
//   in_addr/w_addr/b_addr/out_addr - addresses for the current tap/pixel
//   tap_valid - current tap lies inside the input (not padding)
//   last_tap/last_pixel - current tap/pixel is the final one
module conv2d_mc_addr_gen
  import conv2d_mc_pkg::*;
#(
  parameter int BATCH_SIZE   = 1,
  parameter int IN_CHANNELS  = 2,
  parameter int OUT_CHANNELS = 2,
  parameter int IN_HEIGHT    = 4,
  parameter int IN_WIDTH     = 4,
  parameter int KERNEL_SIZE  = 2,
  parameter int STRIDE       = 2,
  parameter int PADDING      = 0,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  tap_step,
  input  logic                  pix_step,
  output logic [ADDR_WIDTH-1:0] in_addr,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] b_addr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  tap_valid,
  output logic                  last_tap,
  output logic                  last_pixel
);

  localparam int OUT_H = out_dim(IN_HEIGHT, KERNEL_SIZE, STRIDE, PADDING);
  localparam int OUT_W = out_dim(IN_WIDTH, KERNEL_SIZE, STRIDE, PADDING);

  logic [CNT_W-1:0] b, oc, oy, ox, ic, ky, kx;
  logic l_b, l_oc, l_oy, l_ox, l_ic, l_ky, l_kx;
  int   iy, ix;

  assign l_kx = (kx == CNT_W'(KERNEL_SIZE - 1));
  assign l_ky = (ky == CNT_W'(KERNEL_SIZE - 1));
  assign l_ic = (ic == CNT_W'(IN_CHANNELS - 1));
  assign l_ox = (ox == CNT_W'(OUT_W - 1));
  assign l_oy = (oy == CNT_W'(OUT_H - 1));
  assign l_oc = (oc == CNT_W'(OUT_CHANNELS - 1));
  assign l_b  = (b  == CNT_W'(BATCH_SIZE - 1));

  assign last_tap   = l_kx & l_ky & l_ic;
  assign last_pixel = l_ox & l_oy & l_oc & l_b;

  always_comb begin
    iy        = int'(oy) * STRIDE + int'(ky) - PADDING;
    ix        = int'(ox) * STRIDE + int'(kx) - PADDING;
    tap_valid = (iy >= 0) && (iy < IN_HEIGHT) && (ix >= 0) && (ix < IN_WIDTH);
    // A padded tap yields a meaningless address; it is never enabled.
    in_addr   = ADDR_WIDTH'(nchw_addr(int'(b), int'(ic), iy, ix, IN_CHANNELS, IN_HEIGHT, IN_WIDTH));
    w_addr    = ADDR_WIDTH'(oihw_addr(int'(oc), int'(ic), int'(ky), int'(kx), IN_CHANNELS, KERNEL_SIZE));
    b_addr    = ADDR_WIDTH'(oc);
    out_addr  = ADDR_WIDTH'(nchw_addr(int'(b), int'(oc), int'(oy), int'(ox), OUT_CHANNELS, OUT_H, OUT_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {b, oc, oy, ox, ic, ky, kx} <= '0;
    end else if (clr) begin
      {b, oc, oy, ox, ic, ky, kx} <= '0;
    end else begin
      if (tap_step) begin
        kx <= l_kx ? '0 : kx + CNT_W'(1);
        if (l_kx) begin
          ky <= l_ky ? '0 : ky + CNT_W'(1);
          if (l_ky) ic <= l_ic ? '0 : ic + CNT_W'(1);
        end
      end
      if (pix_step) begin
        ox <= l_ox ? '0 : ox + CNT_W'(1);
        if (l_ox) begin
          oy <= l_oy ? '0 : oy + CNT_W'(1);
          if (l_oy) begin
            oc <= l_oc ? '0 : oc + CNT_W'(1);
            if (l_oc) b <= l_b ? '0 : b + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/conv2d_mc_engine.sv
// conv2d_mc_engine: batched multi-output-channel 2-D convolution.
//   Per output pixel: BIAS (bias read), MAC (one tap per cycle), DRAIN (last
//   product lands), WRITE (one output word). NTAP+3 cycles per pixel, plus
//   one FIN cycle per run carrying done.
//   Ports: clk, rst (async, active-high), start, busy, done;
//          input_*/weight_*/bias_* synchronous read ports (data one cycle after en);
//          output_addr/output_data/output_en/output_we/valid write port.
//   Build option: define CONV2D_MC_RELU_EN to clamp negative results to 0.
module conv2d_mc_engine
  import conv2d_mc_pkg::*;
#(
  parameter int BATCH_SIZE   = 1,
  parameter int IN_CHANNELS  = 2,
  parameter int OUT_CHANNELS = 2,
  parameter int IN_HEIGHT    = 4,
  parameter int IN_WIDTH     = 4,
  parameter int KERNEL_SIZE  = 2,
  parameter int STRIDE       = 2,
  parameter int PADDING      = 0,
  parameter int DATA_WIDTH   = 8,
  parameter int ACC_WIDTH    = 24,
  parameter int OUT_SHIFT    = 0,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] input_addr,
  output logic                  input_en,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic [ADDR_WIDTH-1:0] weight_addr,
  output logic                  weight_en,
  input  logic [DATA_WIDTH-1:0] weight_data,
  output logic [ADDR_WIDTH-1:0] bias_addr,
  output logic                  bias_en,
  input  logic [DATA_WIDTH-1:0] bias_data,
  output logic [ADDR_WIDTH-1:0] output_addr,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  output_en,
  output logic                  output_we,
  output logic                  valid
);

`ifdef CONV2D_MC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  state_t state, nstate;

  logic [ADDR_WIDTH-1:0] ag_in, ag_w, ag_b, ag_out;
  logic [ADDR_WIDTH-1:0] in_q, w_q, b_q, out_q;
  logic tap_valid, last_tap, last_pixel;
  logic iss_in, iss_w, iss_b, iss_o;
  logic tap_step, pix_step, clr;

  // Operand pipeline: flags describing what the read ports return this cycle.
  logic first_q;   // bias word is on bias_data
  logic op_ok_q;   // input_data holds a real (non-pad) activation

  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0]          op;
  logic [DATA_WIDTH-1:0]          result;

  conv2d_mc_addr_gen #(
    .BATCH_SIZE  (BATCH_SIZE),
    .IN_CHANNELS (IN_CHANNELS),
    .OUT_CHANNELS(OUT_CHANNELS),
    .IN_HEIGHT   (IN_HEIGHT),
    .IN_WIDTH    (IN_WIDTH),
    .KERNEL_SIZE (KERNEL_SIZE),
    .STRIDE      (STRIDE),
    .PADDING     (PADDING),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_ag (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .tap_step  (tap_step),
    .pix_step  (pix_step),
    .in_addr   (ag_in),
    .w_addr    (ag_w),
    .b_addr    (ag_b),
    .out_addr  (ag_out),
    .tap_valid (tap_valid),
    .last_tap  (last_tap),
    .last_pixel(last_pixel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate   = state;
    iss_in   = 1'b0;
    iss_w    = 1'b0;
    iss_b    = 1'b0;
    iss_o    = 1'b0;
    tap_step = 1'b0;
    pix_step = 1'b0;
    clr      = 1'b0;
    done     = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) begin
          nstate = S_BIAS;
          clr    = 1'b1;
        end
      end
      S_BIAS: begin
        iss_b  = 1'b1;
        nstate = S_MAC;
      end
      S_MAC: begin
        iss_in   = tap_valid;
        iss_w    = 1'b1;
        tap_step = 1'b1;
        if (last_tap) nstate = S_DRAIN;
      end
      S_DRAIN: nstate = S_WRITE;
      S_WRITE: begin
        iss_o    = 1'b1;
        pix_step = 1'b1;
        nstate   = last_pixel ? S_FIN : S_BIAS;
      end
      S_FIN: begin
        done   = 1'b1;
        nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  // Addresses show the live value while enabled and hold it afterwards.
  assign input_en    = iss_in;
  assign weight_en   = iss_w;
  assign bias_en     = iss_b;
  assign output_en   = iss_o;
  assign output_we   = iss_o;
  assign valid       = iss_o;
  assign input_addr  = iss_in ? ag_in  : in_q;
  assign weight_addr = iss_w  ? ag_w   : w_q;
  assign bias_addr   = iss_b  ? ag_b   : b_q;
  assign output_addr = iss_o  ? ag_out : out_q;
  assign output_data = iss_o  ? result : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q  <= '0;
      w_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
    end else begin
      if (iss_in) in_q  <= ag_in;
      if (iss_w)  w_q   <= ag_w;
      if (iss_b)  b_q   <= ag_b;
      if (iss_o)  out_q <= ag_out;
    end
  end

  assign op     = op_ok_q ? input_data : '0;
  assign prod   = $signed(op) * $signed(weight_data);
  assign result = DATA_WIDTH'(sat_shift(longint'(acc), OUT_SHIFT, RELU, DATA_WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q <= 1'b0;
      op_ok_q <= 1'b0;
      acc     <= '0;
    end else begin
      first_q <= (state == S_BIAS);
      op_ok_q <= iss_in;
      if (state == S_MAC && first_q)
        acc <= {{(ACC_WIDTH-DATA_WIDTH){bias_data[DATA_WIDTH-1]}}, bias_data};
      else if (state == S_MAC || state == S_DRAIN)
        acc <= acc + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    end
  end

endmodule

// File: tb/tb_conv2d_mc_engine.sv
// tb_conv2d_mc_engine: directed bench with a write scoreboard.
//   dut 0: default parameters; dut 1: K=3 S=1 P=1; dut 2: OUT_SHIFT=1.
//   Expected writes are queued when a run is launched; a monitor pops and
//   compares on every valid cycle.
module tb_conv2d_mc_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  start, busy, done, ien, wen, ben, oen, owe, vld;
  logic [15:0] iaddr [3], waddr [3], baddr [3], oaddr [3];
  logic [7:0]  idata [3], wdata [3], bdata [3], odata [3];

  logic [7:0] act [3][64];
  logic [7:0] wt  [3][64];
  logic [7:0] bs  [3][4];

  typedef struct { int a; int d; } exp_t;
  exp_t q [3][$];

  int n_chk = 0, n_fail = 0;
  int wr_cnt [3] = '{0, 0, 0};
  int in_cnt [3] = '{0, 0, 0};
  int dn_cnt [3] = '{0, 0, 0};

  int t1 [8]  = '{84, 100, 127, 127, 84, 100, 127, 127};
  int t4 [8]  = '{39, 47, 71, 79, 43, 51, 75, 83};
  int t3 [16] = '{8, 12, 12, 8, 12, 18, 18, 12, 12, 18, 18, 12, 8, 12, 12, 8};

  conv2d_mc_engine u0 (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .input_addr(iaddr[0]), .input_en(ien[0]), .input_data(idata[0]),
    .weight_addr(waddr[0]), .weight_en(wen[0]), .weight_data(wdata[0]),
    .bias_addr(baddr[0]), .bias_en(ben[0]), .bias_data(bdata[0]),
    .output_addr(oaddr[0]), .output_data(odata[0]), .output_en(oen[0]),
    .output_we(owe[0]), .valid(vld[0]));

  conv2d_mc_engine #(.KERNEL_SIZE(3), .STRIDE(1), .PADDING(1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .input_addr(iaddr[1]), .input_en(ien[1]), .input_data(idata[1]),
    .weight_addr(waddr[1]), .weight_en(wen[1]), .weight_data(wdata[1]),
    .bias_addr(baddr[1]), .bias_en(ben[1]), .bias_data(bdata[1]),
    .output_addr(oaddr[1]), .output_data(odata[1]), .output_en(oen[1]),
    .output_we(owe[1]), .valid(vld[1]));

  conv2d_mc_engine #(.OUT_SHIFT(1)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .input_addr(iaddr[2]), .input_en(ien[2]), .input_data(idata[2]),
    .weight_addr(waddr[2]), .weight_en(wen[2]), .weight_data(wdata[2]),
    .bias_addr(baddr[2]), .bias_en(ben[2]), .bias_data(bdata[2]),
    .output_addr(oaddr[2]), .output_data(odata[2]), .output_en(oen[2]),
    .output_we(owe[2]), .valid(vld[2]));

  // Synchronous memories; an unenabled read returns junk so stray use shows up.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      idata[d] <= (ien[d] && iaddr[d] < 64) ? act[d][iaddr[d][5:0]] : 8'h5A;
      wdata[d] <= (wen[d] && waddr[d] < 64) ? wt[d][waddr[d][5:0]]  : 8'h5A;
      bdata[d] <= (ben[d] && baddr[d] < 4)  ? bs[d][baddr[d][1:0]]  : 8'h5A;
    end
  end

  task automatic chk(input string name, input logic signed [63:0] act_v,
                     input logic signed [63:0] exp_v);
    n_chk++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, wanted %0d", name, act_v, exp_v);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ien[d]) in_cnt[d]++;
      if (done[d]) dn_cnt[d]++;
      if (vld[d]) begin
        wr_cnt[d]++;
        if (q[d].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL dut%0d stray write: addr %0d data %0d", d, oaddr[d], $signed(odata[d]));
        end else begin
          exp_t e;
          e = q[d].pop_front();
          chk($sformatf("dut%0d wr addr", d), oaddr[d], e.a);
          chk($sformatf("dut%0d wr data @%0d", d, e.a), $signed(odata[d]), e.d);
          chk($sformatf("dut%0d en/we", d), {oen[d], owe[d]}, 2'b11);
        end
      end
    end
  end

  task automatic push(input int d, input int a, input int v);
    exp_t e;
    e.a = a;
    e.d = v;
    q[d].push_back(e);
  endtask

  // Launch from a point just after a negedge; returns at the negedge after done.
  task automatic run(input int d, input bit hold, output int len);
    start[d] = 1'b1;
    len = 0;
    do begin
      @(negedge clk);
      if (!hold) start[d] = 1'b0;
      len++;
    end while (!done[d] && len < 5000);
    start[d] = 1'b0;
    if (!done[d]) begin
      n_chk++;
      n_fail++;
      $display("FAIL dut%0d run timeout: no done within %0d cycles", d, len);
    end
    @(negedge clk);
    chk($sformatf("dut%0d done one-shot/idle", d), {done[d], busy[d]}, 2'b00);
  endtask

  task automatic load_t1(input int d);
    for (int i = 0; i < 64; i++) begin
      act[d][i] = (i < 32) ? 8'(i) : 8'h00;
      wt[d][i]  = 8'd1;
    end
  endtask

  initial begin
    int len, wc, dc;
    start = '0;
    for (int d = 0; d < 3; d++) begin
      load_t1(d);
      for (int i = 0; i < 4; i++) bs[d][i] = 8'd0;
    end
    for (int i = 0; i < 64; i++) begin
      act[1][i] = 8'd1;
      wt[1][i]  = 8'd1;
    end
    bs[2][0] = -8'sd5;
    bs[2][1] = 8'sd3;

    #2 rst = 1'b1;
    #1;
    chk("reset busy/done/valid", {busy[0], done[0], vld[0], oen[0], owe[0]}, 0);
    chk("reset read enables", {ien[0], wen[0], ben[0]}, 0);
    chk("reset addresses", {iaddr[0], waddr[0], baddr[0], oaddr[0]}, 0);
    chk("reset output_data", odata[0], 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: ramp activations, unit weights, zero bias.
    for (int i = 0; i < 8; i++) push(0, i, t1[i]);
    run(0, 1'b0, len);
    chk("t1 run length", len, 89);
    chk("t1 writes", wr_cnt[0], 8);
    chk("t1 input reads", in_cnt[0], 64);

    // Test 4: signed bias and a 1-bit output shift.
    for (int i = 0; i < 8; i++) push(2, i, t4[i]);
    run(2, 1'b0, len);
    chk("t4 run length", len, 89);

    // Test 2: positive and negative saturation.
    for (int i = 0; i < 64; i++) begin
      act[0][i] = 8'sd127;
      wt[0][i]  = 8'sd127;
    end
    for (int i = 0; i < 8; i++) push(0, i, 127);
    run(0, 1'b0, len);
    for (int i = 0; i < 64; i++) wt[0][i] = 8'h80;
`ifdef CONV2D_MC_RELU_EN
    for (int i = 0; i < 8; i++) push(0, i, 0);
`else
    for (int i = 0; i < 8; i++) push(0, i, -128);
`endif
    run(0, 1'b0, len);

    // Test 3: 3x3 kernel with padding; pad taps must not be read.
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 16; i++) push(1, c * 16 + i, t3[i]);
    run(1, 1'b0, len);
    chk("t3 run length", len, 2 * 16 * 21 + 1);
    chk("t3 input reads (no pad reads)", in_cnt[1], 400);

    // Test 5: reset 30 cycles into a run.
    load_t1(0);
    for (int i = 0; i < 8; i++) push(0, i, t1[i]);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5 busy/valid under reset", {busy[0], vld[0], oen[0], owe[0], done[0]}, 0);
    chk("t5 enables under reset", {ien[0], wen[0], ben[0]}, 0);
    chk("t5 addresses under reset", {iaddr[0], waddr[0], baddr[0], oaddr[0]}, 0);
    @(negedge clk);
    rst = 1'b0;
    q[0].delete();
    wc = wr_cnt[0];
    repeat (20) @(negedge clk);
    chk("t5 no writes after reset", wr_cnt[0] - wc, 0);
    chk("t5 idle after reset", busy[0], 0);
    for (int i = 0; i < 8; i++) push(0, i, t1[i]);
    run(0, 1'b0, len);
    chk("t5 rerun length", len, 89);

    // Test 6: start held through a run, then relaunch right after done.
    wc = wr_cnt[0];
    dc = dn_cnt[0];
    for (int i = 0; i < 8; i++) push(0, i, t1[i]);
    run(0, 1'b1, len);
    chk("t6 held-start run length", len, 89);
    chk("t6 held-start writes", wr_cnt[0] - wc, 8);
    chk("t6 held-start done pulses", dn_cnt[0] - dc, 1);
    for (int i = 0; i < 8; i++) push(0, i, t1[i]);
    run(0, 1'b0, len);
    chk("t6 back-to-back run length", len, 89);
    chk("t6 total writes", wr_cnt[0] - wc, 16);

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) chk($sformatf("dut%0d leftover expected writes", d), q[d].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
